// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
// Holds the 2-bit counter encoding and the saturating update helpers.
// The BTB entry struct depends on XLEN and index width, so each user
// declares it locally from its own parameters.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

  function automatic ctr_t ctr_train(input ctr_t c, input logic taken);
    return taken ? ctr_inc(c) : ctr_dec(c);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of 2-bit saturating counters.
// Ports:
//   clk, reset          clock, async active-high reset (all counters -> WNT)
//   rd_idx / rd_ctr     combinational read port
//   wr_en / wr_idx /    training port; counter moves toward wr_taken
//   wr_taken
// No read-during-write bypass: a same-index read returns the old value.
import bp_pkg::*;

module bp_pht #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX     = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IDX-1:0] rd_idx,
  output ctr_t           rd_ctr,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic           wr_taken
);

  ctr_t pht [ENTRIES];

  // Counter storage and training
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) pht[i] <= WNT;
    end else if (wr_en) begin
      pht[wr_idx] <= ctr_train(pht[wr_idx], wr_taken);
    end
  end

  assign rd_ctr = pht[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit counter PHT.
// Ports:
//   clk, reset                 clock, async active-high reset
//   if_pc                      fetch PC, looked up combinationally
//   pred_taken, pred_target    prediction for the next PC
//   ex_update_valid, ex_pc,    training from the resolving EX stage
//   ex_is_jump, ex_taken,
//   ex_target, ex_mispredict
//   stat_branches,             saturating event counters
//   stat_mispredicts
// Build option: BP_GSHARE_EN selects gshare PHT indexing (PC index XOR a
// non-speculative global history); otherwise the PHT is bimodal and no
// history register exists.
import bp_pkg::*;

module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned GHR_BITS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_update_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             jump;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  logic [IDX-1:0]   if_idx, ex_idx, if_pht_idx, ex_pht_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_entry_t       if_entry;
  ctr_t             if_ctr;
  logic             hit;
  logic             pht_wr;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[XLEN-1:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX+2];

  // Word-offset bits never take part in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, if_pc[1:0], ex_pc[1:0]};

  assign pht_wr = ex_update_valid && !ex_is_jump;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  // Committed history: shifts only when a conditional branch resolves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (pht_wr) begin
      // Truncating the concatenation keeps the newest GHR_BITS outcomes
      ghr <= GHR_BITS'({ghr, ex_taken});
    end
  end

  assign if_pht_idx = if_idx ^ IDX'(ghr);
  assign ex_pht_idx = ex_idx ^ IDX'(ghr);
`else
  assign if_pht_idx = if_idx;
  assign ex_pht_idx = ex_idx;
`endif

  bp_pht #(
    .ENTRIES (ENTRIES),
    .IDX     (IDX)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_pht_idx),
    .rd_ctr   (if_ctr),
    .wr_en    (pht_wr),
    .wr_idx   (ex_pht_idx),
    .wr_taken (ex_taken)
  );

  // Lookup: jumps in the BTB always redirect, branches follow the counter MSB
  assign if_entry    = btb[if_idx];
  assign hit         = if_entry.valid && (if_entry.tag == if_tag);
  assign pred_taken  = hit && (if_entry.jump || if_ctr[1]);
  assign pred_target = pred_taken ? if_entry.target : if_pc + XLEN'(4);

  // BTB allocation on taken outcomes only; not-taken never evicts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) btb[i] <= '0;
    end else if (ex_update_valid && ex_taken) begin
      btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, jump: ex_is_jump};
    end
  end

  // Saturating statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ex_update_valid) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (ex_mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule
